// File: rtl/ds_scoreboard_pkg.sv
// Shared decode-stage constants: default widths, the hard-wired zero
// register index, and the operand source selector used by the resolver.
package ds_scoreboard_pkg;

    localparam int DEF_NREG  = 32;
    localparam int DEF_DW    = 32;
    localparam int DEF_NFWD  = 2;
    localparam int DEF_CNT_W = 2;
    localparam int REG_ZERO  = 0;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_FWD,
        SRC_WB,
        SRC_RF
    } src_sel_e;

endpackage

// File: rtl/ds_scoreboard_src_resolve.sv
// Per-operand source resolver: picks the operand value from the zero
// register, the forwarding channels, the writeback port or the register
// file, and reports whether a used operand must stall issue.
module ds_src_resolve
    import ds_scoreboard_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int DW   = DEF_DW,
    parameter int NFWD = DEF_NFWD,
    parameter int AW   = $clog2(NREG)
) (
    input  logic [AW-1:0]      addr,
    input  logic               src_use,
    input  logic [DW-1:0]      rf_rdata,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD*AW-1:0] fwd_dest,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic [NFWD-1:0]    fwd_ok,
    input  logic               wb_we,
    input  logic [AW-1:0]      wb_waddr,
    input  logic [DW-1:0]      wb_wdata,
    input  logic               pending,
    output logic [DW-1:0]      value,
    output logic               stall
);

    logic          fwd_hit;
    logic [DW-1:0] fwd_value;
    logic          fwd_final;
    src_sel_e      sel;

    // Scan from the oldest channel down so the youngest matching one wins.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_value = '0;
        fwd_final = 1'b1;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_dest[i*AW +: AW] == addr)) begin
                fwd_hit   = 1'b1;
                fwd_value = fwd_data[i*DW +: DW];
                fwd_final = fwd_ok[i];
            end
        end
    end

    // Priority: zero register, forwarding, writeback, then register file.
    always_comb begin
        sel = SRC_RF;
        if (addr == AW'(REG_ZERO)) begin
            sel = SRC_ZERO;
        end else if (fwd_hit) begin
            sel = SRC_FWD;
        end else if (wb_we && (wb_waddr == addr)) begin
            sel = SRC_WB;
        end
    end

    // Drive the value; stall on an unfinished forward or a hidden writer.
    always_comb begin
        value = rf_rdata;
        stall = 1'b0;
        case (sel)
            SRC_ZERO: value = '0;
            SRC_FWD: begin
                value = fwd_value;
                stall = src_use && !fwd_final;
            end
            SRC_WB:   value = wb_wdata;
            default: begin
                value = rf_rdata;
                stall = src_use && pending;
            end
        endcase
    end

endmodule

// File: rtl/ds_scoreboard.sv
// Decode-stage scoreboard: tracks in-flight writers per register with
// small counters, resolves both source operands and decides issue.
module ds_scoreboard
    import ds_scoreboard_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int DW    = DEF_DW,
    parameter int NFWD  = DEF_NFWD,
    parameter int CNT_W = DEF_CNT_W,
    parameter int AW    = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ds_valid,
    input  logic               ds_we,
    input  logic [AW-1:0]      ds_waddr,
    input  logic               ds_use1,
    input  logic               ds_use2,
    input  logic [AW-1:0]      ds_raddr1,
    input  logic [AW-1:0]      ds_raddr2,
    input  logic [DW-1:0]      rf_rdata1,
    input  logic [DW-1:0]      rf_rdata2,
    input  logic               es_allowin,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD*AW-1:0] fwd_dest,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic [NFWD-1:0]    fwd_ok,
    input  logic               wb_we,
    input  logic [AW-1:0]      wb_waddr,
    input  logic [DW-1:0]      wb_wdata,
    input  logic               flush,
    output logic               ds_ready_go,
    output logic [DW-1:0]      src1_value,
    output logic [DW-1:0]      src2_value,
    output logic [NREG-1:0]    busy,
    output logic               err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             stall1;
    logic             stall2;
    logic             writer_full;
    logic             issue_fire;

    ds_src_resolve #(.NREG(NREG), .DW(DW), .NFWD(NFWD), .AW(AW)) u_src1 (
        .addr     (ds_raddr1),
        .src_use  (ds_use1),
        .rf_rdata (rf_rdata1),
        .fwd_we   (fwd_we),
        .fwd_dest (fwd_dest),
        .fwd_data (fwd_data),
        .fwd_ok   (fwd_ok),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .pending  (busy[ds_raddr1]),
        .value    (src1_value),
        .stall    (stall1)
    );

    ds_src_resolve #(.NREG(NREG), .DW(DW), .NFWD(NFWD), .AW(AW)) u_src2 (
        .addr     (ds_raddr2),
        .src_use  (ds_use2),
        .rf_rdata (rf_rdata2),
        .fwd_we   (fwd_we),
        .fwd_dest (fwd_dest),
        .fwd_data (fwd_data),
        .fwd_ok   (fwd_ok),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .pending  (busy[ds_raddr2]),
        .value    (src2_value),
        .stall    (stall2)
    );

    // A register is busy while any writer to it is still in flight.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            busy[i] = (cnt[i] != '0);
        end
    end

    // Hold issue when the destination counter would overflow, unless a
    // retire of the same register frees a slot this cycle.
    always_comb begin
        writer_full = ds_we && (ds_waddr != AW'(REG_ZERO)) &&
                      (cnt[ds_waddr] == CNT_MAX) &&
                      !(wb_we && (wb_waddr == ds_waddr));
        ds_ready_go = !ds_valid || !(stall1 || stall2 || writer_full);
        issue_fire  = ds_valid && ds_ready_go && es_allowin;
    end

    // Per-register increment/decrement requests; register 0 never counts.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_vec[i] = issue_fire && ds_we && (ds_waddr == AW'(i));
            dec_vec[i] = wb_we && (wb_waddr == AW'(i));
        end
    end

    // Counter array update with flush override and sticky underflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            err_underflow <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    if (cnt[i] == '0) begin
                        err_underflow <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/ds_scoreboard.md
DS_SCOREBOARD -- requirements
Module: ds_scoreboard

Interface
REQ-001 The block SHALL have parameter NREG, default 32, meaning architectural register count; register 0 is hard-wired zero.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have parameter NFWD, default 2, meaning forwarding channel count; channel 0 is the youngest stage.
REQ-004 The block SHALL have parameter CNT_W, default 2, meaning per-register in-flight counter width; the maximum count is 2^CNT_W-1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports ds_valid (in, 1), ds_we (in, 1), ds_waddr (in, log2 NREG), ds_use1/ds_use2 (in, 1 each), ds_raddr1/ds_raddr2 (in, log2 NREG): the decode-stage instruction descriptor.
REQ-008 The block SHALL have ports rf_rdata1/rf_rdata2 (in, DW): raw register-file read data.
REQ-009 The block SHALL have port es_allowin (in, 1): the next stage accepts.
REQ-010 The block SHALL have ports fwd_we (in, NFWD), fwd_dest (in, NFWD*log2 NREG), fwd_data (in, NFWD*DW), fwd_ok (in, NFWD: data is final, 0 for a load or divide in progress).
REQ-011 The block SHALL have ports wb_we (in, 1), wb_waddr (in, log2 NREG), wb_wdata (in, DW): the writeback retire port.
REQ-012 The block SHALL have port flush (in, 1): discard all in-flight writers.
REQ-013 The block SHALL have outputs ds_ready_go (1), src1_value/src2_value (DW), busy (NREG bitmap), err_underflow (1, sticky).

Function
REQ-014 Issue fire SHALL be ds_valid & ds_ready_go & es_allowin.
REQ-015 On issue fire with ds_we=1 and ds_waddr!=0, cnt[ds_waddr] SHALL increment at the next edge.
REQ-016 On wb_we=1 and wb_waddr!=0, cnt[wb_waddr] SHALL decrement at the next edge.
REQ-017 An increment and a decrement of the same register in the same cycle SHALL leave its count unchanged.
REQ-018 A decrement of a count already at 0 SHALL keep it at 0 and SHALL set err_underflow, which holds until reset.
REQ-019 When flush=1, all counters SHALL become 0 at the next edge, overriding any simultaneous increment or decrement.
REQ-020 Register 0 SHALL never be counted, and its source value SHALL always be 0.
REQ-021 busy[i] SHALL equal (cnt[i]!=0).
REQ-022 Source value resolution SHALL be combinational, evaluated per operand in this order:
  - address 0 -> 0;
  - otherwise, the lowest-index channel with fwd_we & dest==addr -> its fwd_data;
  - otherwise wb_we & wb_waddr==addr -> wb_wdata;
  - otherwise rf_rdata.
REQ-023 A used operand (ds_useN=1) SHALL be blocked if either:
  - the matched channel has fwd_ok=0; or
  - cnt[addr]!=0 with no channel and no wb match (writer hidden in a non-forwarding stage).
REQ-024 Issue SHALL be blocked when ds_we=1 and cnt[ds_waddr] is at its maximum, except when a same-cycle wb decrement of that register is present.
REQ-025 ds_ready_go SHALL be 0 when any block from REQ-023 or REQ-024 holds, and 1 otherwise.
REQ-026 ds_ready_go SHALL be 1 whenever ds_valid=0.
REQ-027 Unused operands SHALL never cause a stall.
REQ-028 Latency: forwarding and stall decisions SHALL take 0 cycles; scoreboard updates SHALL be visible 1 cycle after the edge.

Reset
REQ-029 While resetn=0, all counters SHALL be 0, busy SHALL be 0 and err_underflow SHALL be 0, immediately and independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard all pending counts; the first cycle after release SHALL behave as an empty scoreboard.

Structure
REQ-031 The default widths and the register-0 index constant SHALL live in the shared mycpu header.
REQ-032 The per-operand resolver SHALL be a single sub-module, ds_src_resolve, instantiated twice.
REQ-033 The counter array SHALL be the only sequential state.

Verification
REQ-034 The bench SHALL cover: issue a writer to r5 (es_allowin=1), then a wb retire of r5 two cycles later -> busy[5] reads 1, then returns to 0; cnt[5] reads 0.
REQ-035 The bench SHALL cover: r5 busy, channel 0 driving dest=5, data=0x1234, fwd_ok=0, ds_use1=1 -> ds_ready_go=0; then fwd_ok=1 -> ds_ready_go=1 and src1_value=0x1234.
REQ-036 The bench SHALL cover: channels 0 and 1 both driving dest=7 with 0xAAAA and 0xBBBB -> src2_value=0xAAAA.
REQ-037 The bench SHALL cover: three writers to r3 issued (cnt=3), a fourth writer offered -> ds_ready_go=0; the same cycle with wb_waddr=3 -> ds_ready_go=1 and cnt remains 3.
REQ-038 The bench SHALL cover: flush together with an issue fire to r9 -> every busy bit is 0 next cycle.
REQ-039 The bench SHALL cover: wb retire of r4 with cnt=0 -> err_underflow=1 and held; then resetn=0 -> err_underflow=0 immediately.
